// File: rtl/rgb_fade_pkg.sv
// rgb_fade_pkg
//   Shared types and the segment action table for the RGB hue-wheel fader.
//   state_t    : sequencer FSM states
//   chan_act_t : what a colour channel does during a segment
//   NUM_SEGS   : segments per hue-wheel revolution (R->Y->G->C->B->M->R)
//   seg_act()  : channel action for a given segment (chan 0=R, 1=G, 2=B)
package rgb_fade_pkg;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  typedef enum logic [1:0] {OFF, RISE, FULL, FALL} chan_act_t;

  localparam int NUM_SEGS = 6;

  function automatic chan_act_t seg_act(input logic [2:0] seg, input logic [1:0] chan);
    chan_act_t act;
    act = OFF;
    case (seg)
      3'd0: act = (chan == 2'd0) ? FULL : (chan == 2'd1) ? RISE : OFF;
      3'd1: act = (chan == 2'd0) ? FALL : (chan == 2'd1) ? FULL : OFF;
      3'd2: act = (chan == 2'd0) ? OFF  : (chan == 2'd1) ? FULL : RISE;
      3'd3: act = (chan == 2'd0) ? OFF  : (chan == 2'd1) ? FALL : FULL;
      3'd4: act = (chan == 2'd0) ? RISE : (chan == 2'd1) ? OFF  : FULL;
      3'd5: act = (chan == 2'd0) ? FULL : (chan == 2'd1) ? OFF  : FALL;
      default: act = OFF;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/rgb_fade_sequencer_pwm_compare.sv
// pwm_compare
//   One LED channel: compares the shared PWM counter with this channel's duty
//   and registers the result (one cycle of latency).
//   clk, rst : clock, asynchronous active-high reset
//   pwm_cnt  : shared free-running PWM counter
//   duty     : channel duty; 0 = always off, full scale = always on
//   led      : registered LED drive, active-high
module pwm_compare #(
  parameter int DW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] pwm_cnt,
  input  logic [DW-1:0] duty,
  output logic          led
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led <= 1'b0;
    end else begin
      led <= (pwm_cnt < duty);
    end
  end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer
//   Walks the three LED duties around the hue wheel in NUM_SEGS crossfade
//   segments and drives the LEDs from one shared PWM counter.
//   clk, rst         : clock, asynchronous active-high reset
//   en               : run enable; low returns to IDLE and clears everything
//   freeze           : pause sequencing; PWM keeps running at current duties
//   red/green/blue   : registered LED drives, active-high
//   seg              : current segment 0..NUM_SEGS-1
//   seg_done         : one-cycle pulse after the step that ends a segment
//   duty_r/g/b       : current channel duties (0..PWM_INTERVAL)
// PWM_INTERVAL must be a multiple of STEPS_PER_SEG so a rising channel lands
// exactly on full scale at the end of its segment.
module rgb_fade_sequencer
  import rgb_fade_pkg::*;
#(
  parameter  int PWM_INTERVAL  = 1200,
  parameter  int STEP_INTERVAL = 12000,
  parameter  int STEPS_PER_SEG = 200,
  localparam int DW            = $clog2(PWM_INTERVAL + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          freeze,
  output logic          red,
  output logic          green,
  output logic          blue,
  output logic [2:0]    seg,
  output logic          seg_done,
  output logic [DW-1:0] duty_r,
  output logic [DW-1:0] duty_g,
  output logic [DW-1:0] duty_b
);

  localparam int PW        = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
  localparam int SW        = (STEPS_PER_SEG > 1) ? $clog2(STEPS_PER_SEG) : 1;
  localparam int DUTY_STEP = PWM_INTERVAL / STEPS_PER_SEG;

  localparam logic [DW-1:0] FULL_DUTY  = DW'(PWM_INTERVAL);
  localparam logic [DW-1:0] STEP_DUTY  = DW'(DUTY_STEP);
  localparam logic [DW-1:0] PWM_LAST   = DW'(PWM_INTERVAL - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_INTERVAL - 1);
  localparam logic [SW-1:0] STEP_LAST  = SW'(STEPS_PER_SEG - 1);
  localparam logic [2:0]    SEG_LAST   = 3'(NUM_SEGS - 1);

  state_t        state_reg, state_next;
  logic [PW-1:0] presc_reg;
  logic [SW-1:0] step_cnt_reg;
  logic [2:0]    seg_reg;
  logic          seg_done_reg;
  logic [DW-1:0] pwm_cnt_reg;
  logic [DW-1:0] duty_reg       [3];
  logic [DW-1:0] duty_step_next [3];
  logic [2:0]    led_vec;
  logic          step_tick;
  logic          seg_end;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next state (en low dominates freeze) ----------------
  always_comb begin
    state_next = state_reg;
    if (!en) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    state_next = RUN;
        RUN:     state_next = freeze ? HOLD : RUN;
        HOLD:    state_next = freeze ? HOLD : RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  // The prescaler only advances in RUN, so a tick can never fire in HOLD.
  always_comb begin
    step_tick = (state_reg == RUN) && (presc_reg == PRESC_LAST);
    seg_end   = step_tick && (step_cnt_reg == STEP_LAST);
  end

  // Per-channel duty after a step, saturating at 0 and full scale.
  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    chan_act_t     act;
    logic [DW-1:0] nxt;

    assign act = seg_act(seg_reg, 2'(gi));

    always_comb begin
      nxt = duty_reg[gi];
      case (act)
        RISE:    nxt = (duty_reg[gi] > FULL_DUTY - STEP_DUTY) ? FULL_DUTY : duty_reg[gi] + STEP_DUTY;
        FALL:    nxt = (duty_reg[gi] < STEP_DUTY) ? '0 : duty_reg[gi] - STEP_DUTY;
        default: nxt = duty_reg[gi];
      endcase
    end

    assign duty_step_next[gi] = nxt;

    pwm_compare #(.DW(DW)) u_pwm (
      .clk     (clk),
      .rst     (rst),
      .pwm_cnt (pwm_cnt_reg),
      .duty    (duty_reg[gi]),
      .led     (led_vec[gi])
    );
  end

  // ---------------- Sequencer datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_reg    <= '0;
      step_cnt_reg <= '0;
      seg_reg      <= '0;
      seg_done_reg <= 1'b0;
      pwm_cnt_reg  <= '0;
      for (int i = 0; i < 3; i++) duty_reg[i] <= '0;
    end else if (!en) begin
      presc_reg    <= '0;
      step_cnt_reg <= '0;
      seg_reg      <= '0;
      seg_done_reg <= 1'b0;
      pwm_cnt_reg  <= '0;
      for (int i = 0; i < 3; i++) duty_reg[i] <= '0;
    end else if (state_reg == IDLE) begin
      // Entering RUN: start on pure red; counters begin from zero.
      presc_reg    <= '0;
      step_cnt_reg <= '0;
      seg_reg      <= '0;
      seg_done_reg <= 1'b0;
      pwm_cnt_reg  <= '0;
      duty_reg[0]  <= FULL_DUTY;
      duty_reg[1]  <= '0;
      duty_reg[2]  <= '0;
    end else begin
      // RUN or HOLD: PWM keeps running in both.
      pwm_cnt_reg  <= (pwm_cnt_reg == PWM_LAST) ? '0 : pwm_cnt_reg + 1'b1;
      seg_done_reg <= seg_end;
      if (state_reg == RUN) begin
        presc_reg <= (presc_reg == PRESC_LAST) ? '0 : presc_reg + 1'b1;
      end
      if (step_tick) begin
        for (int i = 0; i < 3; i++) duty_reg[i] <= duty_step_next[i];
        if (seg_end) begin
          step_cnt_reg <= '0;
          seg_reg      <= (seg_reg == SEG_LAST) ? '0 : seg_reg + 1'b1;
        end else begin
          step_cnt_reg <= step_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign red      = led_vec[0];
  assign green    = led_vec[1];
  assign blue     = led_vec[2];
  assign seg      = seg_reg;
  assign seg_done = seg_done_reg;
  assign duty_r   = duty_reg[0];
  assign duty_g   = duty_reg[1];
  assign duty_b   = duty_reg[2];

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed bench for rgb_fade_sequencer with PWM_INTERVAL=12, STEP_INTERVAL=4,
// STEPS_PER_SEG=3 (DUTY_STEP=4). Time index t counts rising edges after the
// IDLE->RUN load edge (t=0); outputs are sampled on the falling edge after edge t.
module tb_rgb_fade_sequencer;

  localparam int PI  = 12;
  localparam int SI  = 4;
  localparam int SPS = 3;
  localparam int DW  = $clog2(PI + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          freeze;
  logic          red, green, blue;
  logic [2:0]    seg;
  logic          seg_done;
  logic [DW-1:0] duty_r, duty_g, duty_b;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int blue_hi  = 0;

  always #5 clk = ~clk;

  rgb_fade_sequencer #(
    .PWM_INTERVAL  (PI),
    .STEP_INTERVAL (SI),
    .STEPS_PER_SEG (SPS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .freeze   (freeze),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .seg      (seg),
    .seg_done (seg_done),
    .duty_r   (duty_r),
    .duty_g   (duty_g),
    .duty_b   (duty_b)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s = %0d", tag, obs);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; freeze = 1'b0;

    // Power-up reset state
    @(negedge clk);
    check_val("rst_red", red, 0);
    check_val("rst_seg", seg, 0);
    check_val("rst_seg_done", seg_done, 0);
    check_val("rst_duty_r", duty_r, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_val("idle_red", red, 0);
    check_val("idle_duty_r", duty_r, 0);

    en = 1'b1;
    for (int t = 0; t <= 140; t++) begin
      @(negedge clk);
      if (seg_done && t <= 92) done_cnt++;
      if (t >= 30 && t <= 41 && blue) blue_hi++;
      case (t)
        0: begin
          check_val("load_duty_r", duty_r, 12);
          check_val("load_duty_g", duty_g, 0);
          check_val("load_duty_b", duty_b, 0);
          check_val("load_seg", seg, 0);
          check_val("load_red_latency", red, 0);
        end
        1: begin
          check_val("run_red_on", red, 1);
          check_val("run_green_off", green, 0);
          check_val("run_blue_off", blue, 0);
        end
        3:  check_val("pre_tick_duty_g", duty_g, 0);
        4:  check_val("tick1_duty_g", duty_g, 4);
        8:  check_val("tick2_duty_g", duty_g, 8);
        11: begin
          check_val("pre_end_seg_done", seg_done, 0);
          check_val("pre_end_seg", seg, 0);
        end
        12: begin
          check_val("tick3_duty_g", duty_g, 12);
          check_val("seg0_end_done", seg_done, 1);
          check_val("seg0_end_seg", seg, 1);
        end
        13: check_val("seg_done_one_cycle", seg_done, 0);
        24: begin
          check_val("seg1_end_duty_r", duty_r, 0);
          check_val("seg1_end_seg", seg, 2);
        end
        28: begin
          check_val("seg2_duty_b", duty_b, 4);
          freeze = 1'b1;
        end
        40: begin
          check_val("hold_duty_b", duty_b, 4);
          check_val("hold_seg", seg, 2);
          check_val("hold_green_full", green, 1);
          check_val("hold_red_off", red, 0);
        end
        42: check_val("hold_blue_pwm_highs", blue_hi, 4);
        48: begin
          check_val("hold_end_duty_b", duty_b, 4);
          freeze = 1'b0;
        end
        51: check_val("resume_pre_tick_duty_b", duty_b, 4);
        52: check_val("resume_tick_duty_b", duty_b, 8);
        56: begin
          check_val("seg2_end_duty_b", duty_b, 12);
          check_val("seg2_end_seg", seg, 3);
          check_val("seg2_end_done", seg_done, 1);
        end
        80: begin
          check_val("seg4_end_duty_r", duty_r, 12);
          check_val("seg4_end_seg", seg, 5);
        end
        92: begin
          check_val("wrap_seg", seg, 0);
          check_val("wrap_duty_r", duty_r, 12);
          check_val("wrap_duty_g", duty_g, 0);
          check_val("wrap_duty_b", duty_b, 0);
          check_val("wrap_seg_done_count", done_cnt, 6);
        end
        128: check_val("lap2_seg3", seg, 3);
        130: en = 1'b0;
        131: begin
          check_val("disable_seg", seg, 0);
          check_val("disable_duty_r", duty_r, 0);
          check_val("disable_duty_g", duty_g, 0);
          check_val("disable_duty_b", duty_b, 0);
        end
        132: begin
          check_val("disable_red", red, 0);
          check_val("disable_green", green, 0);
          check_val("disable_blue", blue, 0);
          en = 1'b1;
        end
        133: begin
          check_val("restart_duty_r", duty_r, 12);
          check_val("restart_seg", seg, 0);
        end
        134: check_val("restart_red", red, 1);
        137: check_val("restart_tick_duty_g", duty_g, 4);
        default: ;
      endcase
    end

    // Asynchronous reset mid-run, away from any clock edge
    #2 rst = 1'b1;
    #1;
    check_val("async_rst_red", red, 0);
    check_val("async_rst_duty_r", duty_r, 0);
    check_val("async_rst_duty_g", duty_g, 0);
    check_val("async_rst_seg", seg, 0);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_val("post_rst_idle_red", red, 0);
    check_val("post_rst_idle_duty_r", duty_r, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
